// File: rtl/loop_accum_kernel.sv
// -----------------------------------------------------------------------------
// loop_accum_kernel
//
// Hardware form of the software loop
//
//     acc = 0; n = 0;
//     for (i = init_val; pred(i, bound) && n < MAX_ITER; i += step, n++)
//         acc += coef * i;
//
// A run is requested with start while IDLE. The operands are latched on that
// edge and the loop then runs one iteration per enabled clock in RUN. The
// final accumulator is then presented in DONE with a valid/ready handshake.
//
// Parameters
//   WIDTH    : width of the induction variable, bound, step, coefficient and
//              accumulator
//   CMP_MODE : loop-continue predicate
//              0 = unsigned i <  bound
//              1 = unsigned i <= bound
//              2 = i != bound
//              3 = signed   i <  bound
//   MAX_ITER : iteration guard. The iteration counter is clog2(MAX_ITER+1)
//              bits wide.
//
// Ports
//   CLK        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   global enable; low freezes every register (stall)
//   start      in   run request, honoured only in IDLE
//   abort      in   cancel the current run or discard a pending result
//   init_val   in   initial induction value
//   step       in   induction increment (wraps modulo 2^WIDTH)
//   bound      in   predicate bound
//   coef       in   per-iteration coefficient
//   busy       out  high while in RUN
//   res_valid  out  high while in DONE
//   res_ready  in   consumer accepts the result
//   result     out  accumulator value
//   iter_count out  number of iterations executed
//   guard_hit  out  run ended because MAX_ITER was reached
//
// Build option
//   LOOP_ACCUM_KERNEL_SAT_EN : when defined, the accumulation saturates
//   unsigned at 2^WIDTH-1. A product wider than WIDTH bits counts as
//   2^WIDTH-1. When the macro is undefined, the accumulation wraps modulo
//   2^WIDTH.
// -----------------------------------------------------------------------------
module loop_accum_kernel #(
   parameter int WIDTH    = 32,
   parameter int CMP_MODE = 0,
   parameter int MAX_ITER = 65535,
   localparam int ITER_W  = $clog2(MAX_ITER + 1)
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic              en,
   input  logic              start,
   input  logic              abort,
   input  logic [WIDTH-1:0]  init_val,
   input  logic [WIDTH-1:0]  step,
   input  logic [WIDTH-1:0]  bound,
   input  logic [WIDTH-1:0]  coef,
   output logic              busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [WIDTH-1:0]  result,
   output logic [ITER_W-1:0] iter_count,
   output logic              guard_hit
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   i_reg,     i_next;
   logic [WIDTH-1:0]   acc_reg,   acc_next;
   logic [WIDTH-1:0]   step_reg,  step_next;
   logic [WIDTH-1:0]   bound_reg, bound_next;
   logic [WIDTH-1:0]   coef_reg,  coef_next;
   logic [ITER_W-1:0]  count_reg, count_next;
   logic               guard_reg, guard_next;

   // -------------------------------------------------------------------------
   // Loop-continue predicate. The mode is fixed at elaboration, so only one
   // comparator is built.
   // -------------------------------------------------------------------------
   logic pred;

   generate
      if (CMP_MODE == 1) begin : g_pred_le
         assign pred = (i_reg <= bound_reg);
      end else if (CMP_MODE == 2) begin : g_pred_ne
         assign pred = (i_reg != bound_reg);
      end else if (CMP_MODE == 3) begin : g_pred_slt
         assign pred = ($signed(i_reg) < $signed(bound_reg));
      end else begin : g_pred_lt
         assign pred = (i_reg < bound_reg);
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Accumulate term: acc + coef*i
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] acc_sum;

`ifdef LOOP_ACCUM_KERNEL_SAT_EN
   // The full-width product is needed to detect a term that does not fit.
   // The carry out of the add clamps the sum to all ones.
   logic [2*WIDTH-1:0] prod_full;
   logic [WIDTH-1:0]   prod_term;
   logic [WIDTH:0]     sum_ext;

   assign prod_full = {{WIDTH{1'b0}}, coef_reg} * {{WIDTH{1'b0}}, i_reg};
   assign prod_term = (|prod_full[2*WIDTH-1:WIDTH]) ? {WIDTH{1'b1}}
                                                     : prod_full[WIDTH-1:0];
   assign sum_ext   = {1'b0, acc_reg} + {1'b0, prod_term};
   assign acc_sum   = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
`else
   // Only the low WIDTH bits of the product are needed, so the multiply
   // stays WIDTH x WIDTH -> WIDTH.
   logic [WIDTH-1:0] prod_term;

   assign prod_term = coef_reg * i_reg;
   assign acc_sum   = acc_reg + prod_term;
`endif

   // -------------------------------------------------------------------------
   // Next-state and datapath control
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      i_next     = i_reg;
      acc_next   = acc_reg;
      step_next  = step_reg;
      bound_next = bound_reg;
      coef_next  = coef_reg;
      count_next = count_reg;
      guard_next = guard_reg;

      unique case (state_reg)
         IDLE: begin
            // A simultaneous abort cancels the request before it starts.
            if (start && !abort) begin
               i_next     = init_val;
               step_next  = step;
               bound_next = bound;
               coef_next  = coef;
               acc_next   = '0;
               count_next = '0;
               guard_next = 1'b0;
               state_next = RUN;
            end
         end

         RUN: begin
            if (abort) begin
               i_next     = '0;
               acc_next   = '0;
               count_next = '0;
               guard_next = 1'b0;
               state_next = IDLE;
            end else if (pred && (count_reg != MAX_CNT)) begin
               acc_next   = acc_sum;
               i_next     = i_reg + step_reg;
               count_next = count_reg + ITER_W'(1);
            end else begin
               // Exit cycle: the predicate failed or the guard was reached.
               // Nothing is accumulated on this cycle.
               guard_next = pred;
               state_next = DONE;
            end
         end

         DONE: begin
            // A start seen here is ignored. Only the handshake completes.
            if (abort) begin
               i_next     = '0;
               acc_next   = '0;
               count_next = '0;
               guard_next = 1'b0;
               state_next = IDLE;
            end else if (res_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers. en gates every update, so a stall freezes all outputs.
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         i_reg     <= '0;
         acc_reg   <= '0;
         step_reg  <= '0;
         bound_reg <= '0;
         coef_reg  <= '0;
         count_reg <= '0;
         guard_reg <= 1'b0;
      end else if (en) begin
         state_reg <= state_next;
         i_reg     <= i_next;
         acc_reg   <= acc_next;
         step_reg  <= step_next;
         bound_reg <= bound_next;
         coef_reg  <= coef_next;
         count_reg <= count_next;
         guard_reg <= guard_next;
      end
   end

   assign busy       = (state_reg == RUN);
   assign res_valid  = (state_reg == DONE);
   assign result     = acc_reg;
   assign iter_count = count_reg;
   assign guard_hit  = guard_reg;

endmodule

// File: tb/tb_loop_accum_kernel.sv
// -----------------------------------------------------------------------------
// tb_loop_accum_kernel
//
// Directed bench for loop_accum_kernel. Three instances cover three
// configurations:
//   u_a : WIDTH=32, CMP_MODE=0, default MAX_ITER
//         checks the main function, latency, abort, stall and reset
//   u_b : WIDTH=8,  CMP_MODE=0
//         checks overflow handling, with a wrapping or saturating result
//         depending on LOOP_ACCUM_KERNEL_SAT_EN
//   u_c : WIDTH=8,  CMP_MODE=2, MAX_ITER=4
//         checks termination by the iteration guard
// -----------------------------------------------------------------------------
module tb_loop_accum_kernel;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic rst_n;

   // ---------------- instance A ----------------
   logic        en_a, start_a, abort_a, ready_a;
   logic [31:0] init_a, step_a, bound_a, coef_a;
   logic        busy_a, valid_a, guard_a;
   logic [31:0] result_a;
   logic [15:0] iter_a;

   loop_accum_kernel #(.WIDTH(32), .CMP_MODE(0)) u_a (
      .CLK(CLK), .rst_n(rst_n), .en(en_a), .start(start_a), .abort(abort_a),
      .init_val(init_a), .step(step_a), .bound(bound_a), .coef(coef_a),
      .busy(busy_a), .res_valid(valid_a), .res_ready(ready_a),
      .result(result_a), .iter_count(iter_a), .guard_hit(guard_a)
   );

   // ---------------- instance B ----------------
   logic       start_b;
   logic       busy_b, valid_b, guard_b;
   logic [7:0] result_b;
   logic [15:0] iter_b;
   logic       en_b, abort_b, ready_b;
   logic [7:0] init_b, step_b, bound_b, coef_b;

   loop_accum_kernel #(.WIDTH(8), .CMP_MODE(0)) u_b (
      .CLK(CLK), .rst_n(rst_n), .en(en_b), .start(start_b), .abort(abort_b),
      .init_val(init_b), .step(step_b), .bound(bound_b), .coef(coef_b),
      .busy(busy_b), .res_valid(valid_b), .res_ready(ready_b),
      .result(result_b), .iter_count(iter_b), .guard_hit(guard_b)
   );

   // ---------------- instance C ----------------
   logic       start_c;
   logic       busy_c, valid_c, guard_c;
   logic [7:0] result_c;
   logic [2:0] iter_c;
   logic       en_c, abort_c, ready_c;
   logic [7:0] init_c, step_c, bound_c, coef_c;

   loop_accum_kernel #(.WIDTH(8), .CMP_MODE(2), .MAX_ITER(4)) u_c (
      .CLK(CLK), .rst_n(rst_n), .en(en_c), .start(start_c), .abort(abort_c),
      .init_val(init_c), .step(step_c), .bound(bound_c), .coef(coef_c),
      .busy(busy_c), .res_valid(valid_c), .res_ready(ready_c),
      .result(result_c), .iter_count(iter_c), .guard_hit(guard_c)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // Inputs are driven and outputs sampled 1 time unit after a rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Issues a start on instance A. On return the start edge has passed.
   task automatic run_a(input logic [31:0] iv, input logic [31:0] st,
                        input logic [31:0] bd, input logic [31:0] cf);
      init_a  = iv;
      step_a  = st;
      bound_a = bd;
      coef_a  = cf;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      // Scramble the operand inputs so that only the latched copies matter.
      init_a  = 32'h5a5a_0001;
      step_a  = 32'h0000_0007;
      bound_a = 32'h0000_0003;
      coef_a  = 32'h0000_0009;
   endtask

   // Counts edges until res_valid appears on A. The count is bounded.
   task automatic wait_a(output int edges);
      edges = 0;
      while (!valid_a && edges < 300) begin
         tick();
         edges++;
      end
   endtask

   int e;

   initial begin
      rst_n   = 1'b0;
      en_a    = 1'b1; start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b0;
      init_a  = '0;   step_a  = '0;   bound_a = '0;   coef_a  = '0;
      en_b    = 1'b1; start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0;
      init_b  = 8'd1; step_b  = 8'd1; bound_b = 8'd3; coef_b  = 8'd100;
      en_c    = 1'b1; start_c = 1'b0; abort_c = 1'b0; ready_c = 1'b0;
      init_c  = 8'd1; step_c  = 8'd2; bound_c = 8'd0; coef_c  = 8'd1;

      // ---------------- reset state ----------------
      tick(); tick();
      check("rst_busy",   busy_a,   0);
      check("rst_valid",  valid_a,  0);
      check("rst_result", result_a, 0);
      check("rst_iter",   iter_a,   0);
      check("rst_guard",  guard_a,  0);
      rst_n = 1'b1;
      tick();

      // ---------------- 5-iteration run: 0+6+12+18+24 = 60 ----------------
      run_a(32'd0, 32'd2, 32'd10, 32'd3);
      check("run_busy", busy_a, 1);
      wait_a(e);
      check("run_latency", e, 6);
      check("run_result", result_a, 60);
      check("run_iter",   iter_a,   5);
      check("run_guard",  guard_a,  0);
      // With res_ready low, the result stays put. A start here is ignored.
      start_a = 1'b1;
      repeat (3) tick();
      start_a = 1'b0;
      check("hold_valid",  valid_a,  1);
      check("hold_result", result_a, 60);
      check("hold_busy",   busy_a,   0);
      // Start together with ready completes only the handshake.
      start_a = 1'b1; ready_a = 1'b1;
      tick();
      start_a = 1'b0; ready_a = 1'b0;
      check("hs_valid", valid_a, 0);
      tick();
      check("hs_no_rerun", busy_a, 0);

      // ---------------- zero trip ----------------
      run_a(32'd10, 32'd2, 32'd10, 32'd3);
      wait_a(e);
      check("zt_latency", e, 1);
      check("zt_result", result_a, 0);
      check("zt_iter",   iter_a,   0);
      ready_a = 1'b1; tick(); ready_a = 1'b0;

      // ---------------- abort in 3rd RUN cycle, then a fresh run ----------------
      run_a(32'd0, 32'd1, 32'd10, 32'd1);
      tick(); tick();
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      check("abort_busy",  busy_a,  0);
      check("abort_valid", valid_a, 0);
      repeat (12) tick();
      check("abort_no_valid", valid_a, 0);
      // i = 1,2,3 with coef 2 gives 2+4+6 = 12
      run_a(32'd1, 32'd1, 32'd4, 32'd2);
      wait_a(e);
      check("fresh_latency", e, 4);
      check("fresh_result", result_a, 12);
      check("fresh_iter",   iter_a,   3);
      ready_a = 1'b1; tick(); ready_a = 1'b0;

      // ---------------- stall: en low for 3 cycles mid-run ----------------
      run_a(32'd0, 32'd2, 32'd10, 32'd3);
      tick(); tick();
      en_a = 1'b0;
      repeat (3) tick();
      check("stall_iter", iter_a, 2);
      check("stall_busy", busy_a, 1);
      en_a = 1'b1;
      // A start while busy, with other operands, must be ignored.
      init_a = 32'd1; step_a = 32'd1; bound_a = 32'd3; coef_a = 32'd5;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_a(e);
      check("stall_latency", e + 6, 9);
      check("stall_result", result_a, 60);
      // Freeze during the handshake.
      en_a = 1'b0; ready_a = 1'b1;
      tick(); tick();
      check("stall_hs_valid", valid_a, 1);
      en_a = 1'b1;
      tick();
      ready_a = 1'b0;
      check("stall_hs_done", valid_a, 0);

      // ---------------- reset mid-RUN ----------------
      run_a(32'd0, 32'd1, 32'd10, 32'd1);
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check("rrun_busy",   busy_a,   0);
      check("rrun_result", result_a, 0);
      check("rrun_iter",   iter_a,   0);
      #2;
      rst_n = 1'b1;
      repeat (3) tick();
      check("rrun_no_resume", busy_a, 0);

      // ---------------- reset while res_valid ----------------
      run_a(32'd0, 32'd2, 32'd10, 32'd3);
      wait_a(e);
      check("rdone_pre", result_a, 60);
      rst_n = 1'b0;
      #1;
      check("rdone_valid",  valid_a,  0);
      check("rdone_result", result_a, 0);
      check("rdone_iter",   iter_a,   0);
      #2;
      rst_n = 1'b1;
      tick();

      // ---------------- WIDTH=8 overflow: 100*1 + 100*2 ----------------
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      e = 0;
      while (!valid_b && e < 50) begin tick(); e++; end
      check("w8_latency", e, 3);
      check("w8_iter",    iter_b, 2);
`ifdef LOOP_ACCUM_KERNEL_SAT_EN
      check("w8_result_sat", result_b, 255);
`else
      check("w8_result_wrap", result_b, 44);
`endif

      // ---------------- guard: i = 1,3,5,7 -> 16 ----------------
      start_c = 1'b1;
      tick();
      start_c = 1'b0;
      e = 0;
      while (!valid_c && e < 50) begin tick(); e++; end
      check("grd_latency", e, 5);
      check("grd_hit",    guard_c,  1);
      check("grd_iter",   iter_c,   4);
      check("grd_result", result_c, 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
